rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Writer end of the register-file write port (we/wR/wD). Collects results from two producers,
//   EX (ALU/branch-link) and LSU (load data), buffers each in its own FIFO, round-robin
//   arbitrates, and issues at most one registered RF write per cycle. Sits between the
//   execute/memory stages and the RF. Upstream scoreboard guarantees no two in-flight results
//   target the same register, so cross-source ordering is irrelevant.
// PARAMETERS
//   DEPTH   4   entries per source FIFO; power of two, >= 2
//   AW      5   register-address width (32 architectural regs)
//   DW      32  data width
// PORTS
//   cpu_clk      in   1      clock; all state on rising edge
//   cpu_rst_n    in   1      asynchronous, active-low reset
//   ex_valid     in   1      EX result valid
//   ex_ready     out  1      EX FIFO can accept (= !ex_full)
//   ex_dst       in   AW     EX destination register
//   ex_data      in   DW     EX result
//   lsu_valid    in   1      LSU result valid
//   lsu_ready    out  1      LSU FIFO can accept (= !lsu_full)
//   lsu_dst      in   AW     LSU destination register
//   lsu_data     in   DW     LSU load data
//   rf_we        out  1      RF write enable (registered)
//   rf_wR        out  AW     RF write address (registered)
//   rf_wD        out  DW     RF write data (registered)
//   wb_idle      out  1      both FIFOs empty and rf_we == 0
//   pend_mask    out  32     (RF_WB_PENDING_EN only) per-register queued-write bitmap
// BEHAVIOUR
//   Reset: rf_we=0, rf_wR=0, rf_wD=0, both FIFOs empty, rr_last=LSU (EX wins first tie),
//     wb_idle=1, pend_mask=0. Reset mid-operation discards all queued entries.
//   Accept: push when x_valid & x_ready. x_ready depends only on FIFO fullness; no same-cycle
//     push-through on a full FIFO even if that FIFO pops this cycle.
//   dst==0 entries: accepted normally, but never produce rf_we=1; the pop still occurs.
//   Arbitration each cycle: one FIFO non-empty -> pop it. Both non-empty -> pop the source not
//     granted last; update rr_last to granted source. Neither -> no pop, rr_last unchanged.
//   Output stage: on pop, next cycle rf_we=(dst!=0), rf_wR=dst, rf_wD=data; else rf_we=0,
//     rf_wR/rf_wD hold. RF never back-pressures, so the pop rate is 1/cycle.
//   Latency: push in cycle N into empty FIFO, no contention -> rf_we=1 in cycle N+2
//     (N+1 pop from FIFO head, registered output visible N+2).
//   FIFO: wr/rd pointers AW_P=$clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when low bits
//     equal and MSBs differ; empty when equal. Simultaneous push+pop on non-full,
//     non-empty FIFO keeps count constant. Push to empty FIFO + pop same cycle: no pop
//     (head not valid until next cycle).
//   wb_idle: combinational, ex_empty & lsu_empty & !rf_we.
// CONFIGURATION
//   `RF_WB_PENDING_EN defined: pend_mask[i]=1 iff some queued entry in either FIFO, or the
//     registered output with rf_we=1, targets reg i (i!=0); bit 0 always 0. Maintained as a
//     registered bitmap: set on push (dst!=0), cleared when the corresponding write is on
//     rf_we. Set and clear of same bit in one cycle -> set wins (new entry pending).
//     Used by issue logic for RAW stall.
//   Not defined: pend_mask port absent; no bitmap flops.
// STRUCTURE
//   Shared package/defines: REG_AW=5, XLEN=32, typedef wb_entry_t {dst[4:0], data[31:0]},
//     SRC_EX=1'b0 / SRC_LSU=1'b1 encodings.
//   One sub-module: wb_fifo (DEPTH, width AW+DW; push/pop/full/empty/head), instantiated
//     twice. Arbiter, output register and pend bitmap live in the top.
// TESTING
//   1 Single EX push dst=5 data=0xDEADBEEF at cycle N -> rf_we=1, rf_wR=5, rf_wD=0xDEADBEEF
//     at N+2 only; wb_idle=1 again at N+3.
//   2 Both FIFOs hold 3 entries (EX dst 1,2,3; LSU dst 9,10,11) -> writes appear in order
//     1,9,2,10,3,11 on six consecutive cycles.
//   3 EX push dst=0 data=0x1234 -> FIFO drains, rf_we stays 0, ex_ready stays 1.
//   4 Push DEPTH=4 LSU entries, no pops possible blocked by test hold of earlier cycle ->
//     lsu_ready=0 after 4th push; 5th lsu_valid held until ready returns, no entry lost or
//     duplicated (scoreboard compare of all writes).
//   5 Assert cpu_rst_n=0 with 2 entries queued -> rf_we=0 immediately (async), after release
//     no writes issued, wb_idle=1.
//   6 (`RF_WB_PENDING_EN) push LSU dst=7 -> pend_mask[7]=1 next cycle; clears the cycle
//     after rf_we with rf_wR=7; re-push dst=7 on clear cycle keeps bit 1.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and encodings for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer-side handshakes and RF write port of the writeback arbiter.
// pend_mask exists only when RF_WB_PENDING_EN is defined.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned AW = REG_AW,
  parameter int unsigned DW = XLEN
);
  logic          ex_valid;
  logic          ex_ready;
  logic [AW-1:0] ex_dst;
  logic [DW-1:0] ex_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_dst;
  logic [DW-1:0] lsu_data;
  logic          rf_we;
  logic [AW-1:0] rf_wR;
  logic [DW-1:0] rf_wD;
  logic          wb_idle;
`ifdef RF_WB_PENDING_EN
  logic [31:0]   pend_mask;

  modport master (
    output ex_valid, ex_dst, ex_data, lsu_valid, lsu_dst, lsu_data,
    input  ex_ready, lsu_ready, rf_we, rf_wR, rf_wD, wb_idle, pend_mask
  );
  modport slave (
    input  ex_valid, ex_dst, ex_data, lsu_valid, lsu_dst, lsu_data,
    output ex_ready, lsu_ready, rf_we, rf_wR, rf_wD, wb_idle, pend_mask
  );
`else
  modport master (
    output ex_valid, ex_dst, ex_data, lsu_valid, lsu_dst, lsu_data,
    input  ex_ready, lsu_ready, rf_we, rf_wR, rf_wD, wb_idle
  );
  modport slave (
    input  ex_valid, ex_dst, ex_data, lsu_valid, lsu_dst, lsu_data,
    output ex_ready, lsu_ready, rf_we, rf_wR, rf_wD, wb_idle
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Per-source result FIFO; pointers carry one extra wrap bit to tell full from empty.
module rf_wb_arbiter_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int unsigned AW_P = $clog2(DEPTH) + 1;
  localparam int unsigned IW   = AW_P - 1;

  logic [AW_P-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic            do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

  // Gating on full/empty: no push-through when full, no pop of a same-cycle push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW_P'(do_push);
    rd_ptr_d = rd_ptr_q + AW_P'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// RF writeback arbiter: two result FIFOs, round-robin pop, registered RF write port.
// Optional RF_WB_PENDING_EN adds the pend_mask pending-write bitmap.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = XLEN
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  rf_wb_arbiter_if.slave  bus
);
  localparam int unsigned EW = AW + DW;

  logic          ex_push, ex_pop, ex_full, ex_empty;
  logic          lsu_push, lsu_pop, lsu_full, lsu_empty;
  logic [EW-1:0] ex_head, lsu_head, pop_entry;
  src_e          rr_last_q, rr_last_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wr_q, rf_wr_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;

  assign bus.ex_ready  = ~ex_full;
  assign bus.lsu_ready = ~lsu_full;
  assign ex_push       = bus.ex_valid & ~ex_full;
  assign lsu_push      = bus.lsu_valid & ~lsu_full;

  rf_wb_arbiter_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ex_fifo (
    .clk_i   (cpu_clk),
    .rst_ni  (cpu_rst_n),
    .push_i  (ex_push),
    .wdata_i ({bus.ex_dst, bus.ex_data}),
    .pop_i   (ex_pop),
    .full_o  (ex_full),
    .empty_o (ex_empty),
    .head_o  (ex_head)
  );

  rf_wb_arbiter_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_lsu_fifo (
    .clk_i   (cpu_clk),
    .rst_ni  (cpu_rst_n),
    .push_i  (lsu_push),
    .wdata_i ({bus.lsu_dst, bus.lsu_data}),
    .pop_i   (lsu_pop),
    .full_o  (lsu_full),
    .empty_o (lsu_empty),
    .head_o  (lsu_head)
  );

  // EX goes when it is the only source, or on a tie when LSU was granted last.
  always_comb begin
    ex_pop    = 1'b0;
    lsu_pop   = 1'b0;
    rr_last_d = rr_last_q;
    if (!ex_empty && (lsu_empty || rr_last_q == SRC_LSU)) begin
      ex_pop    = 1'b1;
      rr_last_d = SRC_EX;
    end else if (!lsu_empty) begin
      lsu_pop   = 1'b1;
      rr_last_d = SRC_LSU;
    end
    pop_entry = ex_pop ? ex_head : lsu_head;
    rf_we_d   = 1'b0;
    rf_wr_d   = rf_wr_q;
    rf_wd_d   = rf_wd_q;
    if (ex_pop || lsu_pop) begin
      rf_wr_d = pop_entry[EW-1:DW];
      rf_wd_d = pop_entry[DW-1:0];
      rf_we_d = (pop_entry[EW-1:DW] != '0);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rr_last_q <= SRC_LSU;
      rf_we_q   <= 1'b0;
      rf_wr_q   <= '0;
      rf_wd_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      rf_we_q   <= rf_we_d;
      rf_wr_q   <= rf_wr_d;
      rf_wd_q   <= rf_wd_d;
    end
  end

  assign bus.rf_we   = rf_we_q;
  assign bus.rf_wR   = rf_wr_q;
  assign bus.rf_wD   = rf_wd_q;
  assign bus.wb_idle = ex_empty & lsu_empty & ~rf_we_q;

`ifdef RF_WB_PENDING_EN
  logic [31:0] pend_q, pend_d;

  // Clear for the write now on the port, then set for new pushes so a re-push wins.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 1; i < 32; i++) begin
      if (rf_we_q && rf_wr_q == AW'(i)) pend_d[i] = 1'b0;
      if (ex_push && bus.ex_dst == AW'(i)) pend_d[i] = 1'b1;
      if (lsu_push && bus.lsu_dst == AW'(i)) pend_d[i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign bus.pend_mask = pend_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  rf_wb_arbiter_if #(.AW(REG_AW), .DW(XLEN)) bus ();

  rf_wb_arbiter #(
    .DEPTH (DEPTH),
    .AW    (REG_AW),
    .DW    (XLEN)
  ) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: plain queues, last-granted flag and the visible write port.
  wb_entry_t   m_exq[$];
  wb_entry_t   m_lsuq[$];
  bit          m_last_lsu;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (m_exq[i]) p[m_exq[i].dst] = 1'b1;
    foreach (m_lsuq[i]) p[m_lsuq[i].dst] = 1'b1;
    if (m_we) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_exq.delete();
    m_lsuq.delete();
    m_last_lsu = 1'b1;
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  task automatic model_edge(input bit ex_acc, input wb_entry_t ex_e,
                            input bit l_acc, input wb_entry_t l_e);
    wb_entry_t g;
    bit popped = 1'b0;
    if (m_exq.size() != 0 && (m_lsuq.size() == 0 || m_last_lsu)) begin
      g = m_exq.pop_front();
      m_last_lsu = 1'b0;
      popped = 1'b1;
    end else if (m_lsuq.size() != 0) begin
      g = m_lsuq.pop_front();
      m_last_lsu = 1'b1;
      popped = 1'b1;
    end
    if (popped) begin
      m_we = (g.dst != 0);
      m_wr = g.dst;
      m_wd = g.data;
    end else begin
      m_we = 1'b0;
    end
    if (ex_acc) m_exq.push_back(ex_e);
    if (l_acc) m_lsuq.push_back(l_e);
  endtask

  task automatic compare_all();
    chk("ex_ready", bus.ex_ready, m_exq.size() < DEPTH);
    chk("lsu_ready", bus.lsu_ready, m_lsuq.size() < DEPTH);
    chk("rf_we", bus.rf_we, m_we);
    chk("rf_wR", bus.rf_wR, m_wr);
    chk("rf_wD", bus.rf_wD, m_wd);
    chk("wb_idle", bus.wb_idle, m_exq.size() == 0 && m_lsuq.size() == 0 && !m_we);
`ifdef RF_WB_PENDING_EN
    chk("pend_mask", bus.pend_mask, m_pend());
`endif
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic cycle(input bit exv, input logic [4:0] exd, input logic [31:0] exdat,
                       input bit lv, input logic [4:0] ld, input logic [31:0] ldat,
                       output bit ex_acc, output bit l_acc);
    wb_entry_t ee, le;
    bus.ex_valid  = exv;
    bus.ex_dst    = exd;
    bus.ex_data   = exdat;
    bus.lsu_valid = lv;
    bus.lsu_dst   = ld;
    bus.lsu_data  = ldat;
    ex_acc = exv && (m_exq.size() < DEPTH);
    l_acc  = lv && (m_lsuq.size() < DEPTH);
    ee = '{dst: exd, data: exdat};
    le = '{dst: ld, data: ldat};
    @(posedge clk);
    model_edge(ex_acc, ee, l_acc, le);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, a, b);
  endtask

  task automatic do_reset();
    bus.ex_valid  = 1'b0;
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic bit in_queues(input logic [4:0] d);
    foreach (m_exq[i]) if (m_exq[i].dst == d) return 1'b1;
    foreach (m_lsuq[i]) if (m_lsuq[i].dst == d) return 1'b1;
    return 1'b0;
  endfunction

  // Destinations honour the upstream scoreboard: no two queued results share a register.
  function automatic logic [4:0] pick(input bit excl_v, input logic [4:0] excl_d);
    logic [4:0] d;
    for (int t = 0; t < 1000; t++) begin
      d = 5'($urandom_range(0, 31));
      if (d == 0) return d;
      if (!in_queues(d) && !(excl_v && excl_d == d)) return d;
    end
    return 5'd0;
  endfunction

  initial begin
    bit ea, la;
    int log2 [8];
    int exp2 [8] = '{-1, 1, 9, 2, 10, 3, 11, -1};
    int acc_cnt, wr_cnt;
    bit saw_block;
    bit exv, lv;
    logic [4:0] exd, ld;
    logic [31:0] exdat, ldat;

    rst_n = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_dst = '0; bus.ex_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_dst = '0; bus.lsu_data = '0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_rf_wR", bus.rf_wR, 5'd0);
    chk("reset_rf_wD", bus.rf_wD, 32'd0);
    chk("reset_wb_idle", bus.wb_idle, 1'b1);
    chk("reset_ex_ready", bus.ex_ready, 1'b1);
    rst_n = 1'b1;

    // Single EX write: latency two, idle again one cycle later.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, ea, la);
    chk("t1_n1_we", bus.rf_we, 1'b0);
    idle(1);
    chk("t1_n2_we", bus.rf_we, 1'b1);
    chk("t1_n2_wR", bus.rf_wR, 5'd5);
    chk("t1_n2_wD", bus.rf_wD, 32'hDEADBEEF);
    idle(1);
    chk("t1_n3_we", bus.rf_we, 1'b0);
    chk("t1_n3_idle", bus.wb_idle, 1'b1);

    // Round-robin interleave from reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) cycle(1'b1, 5'(1 + i), 32'(100 + i), 1'b1, 5'(9 + i), 32'(200 + i), ea, la);
      else idle(1);
      log2[i] = bus.rf_we ? int'(bus.rf_wR) : -1;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("t2_order%0d", i), 64'(log2[i]), 64'(exp2[i]));

    // dst 0 drains silently.
    do_reset();
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, ea, la);
    for (int i = 0; i < 3; i++) begin
      chk("t3_we", bus.rf_we, 1'b0);
      chk("t3_ex_ready", bus.ex_ready, 1'b1);
      idle(1);
    end
    chk("t3_idle", bus.wb_idle, 1'b1);

    // Saturate both sources so the LSU FIFO fills; held valids must not lose or duplicate.
    do_reset();
    acc_cnt = 0; wr_cnt = 0; saw_block = 1'b0;
    exv = 1'b0; lv = 1'b0;
    for (int k = 0, ke = 0, kl = 0; k < 40; k++) begin
      if (!exv && k < 28) begin exv = 1'b1; exd = 5'(1 + ke % 15); exdat = $urandom; ke++; end
      if (!lv && k < 28) begin lv = 1'b1; ld = 5'(16 + kl % 15); ldat = $urandom; kl++; end
      cycle(exv, exd, exdat, lv, ld, ldat, ea, la);
      if (ea) begin exv = 1'b0; acc_cnt++; end
      if (la) begin lv = 1'b0; acc_cnt++; end
      if (bus.rf_we) wr_cnt++;
      if (!bus.lsu_ready) saw_block = 1'b1;
    end
    chk("t4_lsu_blocked", saw_block, 1'b1);
    chk("t4_write_count", 64'(wr_cnt), 64'(acc_cnt));

    // Async reset with entries in flight.
    do_reset();
    cycle(1'b1, 5'd3, 32'hA, 1'b0, '0, '0, ea, la);
    cycle(1'b1, 5'd4, 32'hB, 1'b0, '0, '0, ea, la);
    chk("t5_pre_we", bus.rf_we, 1'b1);
    bus.ex_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_we", bus.rf_we, 1'b0);
    chk("t5_async_idle", bus.wb_idle, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t5_post_we", bus.rf_we, 1'b0);
    end
    chk("t5_post_idle", bus.wb_idle, 1'b1);

`ifdef RF_WB_PENDING_EN
    do_reset();
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, ea, la);
    chk("t6_set", bus.pend_mask[7], 1'b1);
    idle(1);
    chk("t6_we7", bus.rf_we && bus.rf_wR == 5'd7, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h78, ea, la);
    chk("t6_set_wins", bus.pend_mask[7], 1'b1);
    idle(4);
    chk("t6_clear", bus.pend_mask, 32'd0);
`endif

    // Randomised traffic against the model.
    do_reset();
    exv = 1'b0; lv = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      int p;
      p = ((k / 300) % 3 == 0) ? 25 : (((k / 300) % 3 == 1) ? 60 : 95);
      if (!exv && $urandom_range(0, 99) < p) begin
        exd = pick(lv, ld); exdat = $urandom; exv = 1'b1;
      end
      if (!lv && $urandom_range(0, 99) < p) begin
        ld = pick(exv, exd); ldat = $urandom; lv = 1'b1;
      end
      cycle(exv, exd, exdat, lv, ld, ldat, ea, la);
      if (ea) exv = 1'b0;
      if (la) lv = 1'b0;
    end
    idle(12);
    chk("final_idle", bus.wb_idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
